cpu_sequencer: RTL and testbench

//  Control FSM for the 3-stage fetch/decode/execute CPU.
//  - Fetches each 8-bit instruction as two 4-bit memory beats into the two register_half

---
 rtl/cpu_sequencer_pkg.sv | 24 ++
 rtl/cpu_sequencer_pc_counter.sv | 37 +++
 rtl/cpu_sequencer.sv | 126 ++++++++++++
 tb/tb_cpu_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared state encodings, opcode defaults and widths for the CPU sequencer and decoder.
package cpu_sequencer_pkg;

    localparam int unsigned PC_W_DEF = 8;
    localparam int unsigned OPC_W    = 4;

    localparam logic [OPC_W-1:0] HALT_OPC_DEF = 4'hF;
    localparam logic [OPC_W-1:0] JMP_OPC_DEF  = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_HI = 3'd1,
        S_FETCH_LO = 3'd2,
        S_DECODE   = 3'd3,
        S_EXECUTE  = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    // True in either memory beat state.
    function automatic logic is_fetch(input state_t s);
        return (s == S_FETCH_HI) || (s == S_FETCH_LO);
    endfunction

endpackage

// File: rtl/cpu_sequencer_pc_counter.sv
// Program counter register: synchronous reset, load beats increment, wraps modulo 2**W.
module cpu_sequencer_pc_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         res,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // Next count: load wins over increment; natural overflow gives the wrap.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = din;
        end else if (inc) begin
            q_d = q_q + W'(1);
        end
    end

    // Count register with synchronous reset to 0.
    always_ff @(posedge clk) begin
        if (res) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control FSM: two-beat IR fetch, PC ownership, datapath enables.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int unsigned      PC_W     = PC_W_DEF,
    parameter logic [OPC_W-1:0] HALT_OPC = HALT_OPC_DEF,
    parameter logic [OPC_W-1:0] JMP_OPC  = JMP_OPC_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             mem_ack,
    input  logic             stall,
    input  logic [OPC_W-1:0] opcode,
    input  logic [OPC_W-1:0] operand,
    output logic             mem_req,
    output logic             mem_half,
    output logic [PC_W-1:0]  pc,
    output logic             ir_hi_en,
    output logic             ir_lo_en,
    output logic             acc_en,
    output logic             busy,
    output logic             halted
);

    state_t state_d, state_q;
    logic   pc_inc, pc_load;
    logic   mem_req_d, mem_req_q;
    logic   mem_half_d, mem_half_q;
    logic   busy_d, busy_q;
    logic   halted_d, halted_q;

    // Next state and enables; enables follow mem_ack in the same cycle, reset suppresses all.
    always_comb begin
        state_d  = state_q;
        ir_hi_en = 1'b0;
        ir_lo_en = 1'b0;
        acc_en   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH_HI;
            end
            S_FETCH_HI: begin
                if (mem_ack) begin
                    ir_hi_en = 1'b1;
                    state_d  = S_FETCH_LO;
                end
            end
            S_FETCH_LO: begin
                if (mem_ack) begin
                    ir_lo_en = 1'b1;
                    pc_inc   = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (opcode == HALT_OPC) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                if (!stall) begin
                    if (opcode == JMP_OPC) pc_load = 1'b1;
                    else                   acc_en  = 1'b1;
                    state_d = S_FETCH_HI;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (res) begin
            state_d  = S_IDLE;
            ir_hi_en = 1'b0;
            ir_lo_en = 1'b0;
            acc_en   = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
        end
    end

    // Status outputs decoded from the next state so their flops line up with state_q.
    always_comb begin
        mem_req_d  = is_fetch(state_d);
        mem_half_d = (state_d == S_FETCH_LO);
        busy_d     = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d   = (state_d == S_HALT);
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_half_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_half_q <= mem_half_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_half = mem_half_q;
    assign busy     = busy_q;
    assign halted   = halted_q;

    cpu_sequencer_pc_counter #(
        .W(PC_W)
    ) u_pc (
        .clk  (clk),
        .res  (res),
        .inc  (pc_inc),
        .load (pc_load),
        .din  (PC_W'(operand)),
        .q    (pc)
    );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: vector table through a scoreboard, plus a PC wrap run.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       start = 1'b0;
    logic       mem_ack = 1'b0;
    logic       stall = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [3:0] operand = 4'h0;
    logic       mem_req, mem_half, ir_hi_en, ir_lo_en, acc_en, busy, halted;
    logic [7:0] pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .mem_ack  (mem_ack),
        .stall    (stall),
        .opcode   (opcode),
        .operand  (operand),
        .mem_req  (mem_req),
        .mem_half (mem_half),
        .pc       (pc),
        .ir_hi_en (ir_hi_en),
        .ir_lo_en (ir_lo_en),
        .acc_en   (acc_en),
        .busy     (busy),
        .halted   (halted)
    );

    // Flag order: {mem_req, mem_half, ir_hi_en, ir_lo_en, acc_en, busy, halted}
    localparam logic [6:0] F_IDL  = 7'b0000000;
    localparam logic [6:0] F_HI   = 7'b1010010;
    localparam logic [6:0] F_WAIT = 7'b1000010;
    localparam logic [6:0] F_LO   = 7'b1101010;
    localparam logic [6:0] F_DEC  = 7'b0000010;
    localparam logic [6:0] F_EXA  = 7'b0000110;
    localparam logic [6:0] F_HALT = 7'b0000001;

    typedef struct packed {
        logic       r;
        logic       s;
        logic       a;
        logic       st;
        logic [3:0] oc;
        logic [3:0] od;
        logic [14:0] exp;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];
    logic [14:0] sb_q [$];

    function automatic vec_t v(input logic r, input logic s, input logic a, input logic st,
                               input logic [3:0] oc, input logic [3:0] od,
                               input logic [6:0] f, input logic [7:0] p);
        vec_t t;
        t.r = r; t.s = s; t.a = a; t.st = st; t.oc = oc; t.od = od;
        t.exp = {f, p};
        return t;
    endfunction

    function automatic logic [14:0] observed();
        return {mem_req, mem_half, ir_hi_en, ir_lo_en, acc_en, busy, halted, pc};
    endfunction

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic apply(input int idx);
        logic [14:0] e;
        @(negedge clk);
        res = vecs[idx].r; start = vecs[idx].s; mem_ack = vecs[idx].a;
        stall = vecs[idx].st; opcode = vecs[idx].oc; operand = vecs[idx].od;
        sb_q.push_back(vecs[idx].exp);
        #2;
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_empty vec%0d got=empty exp=entry", idx);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("vec%0d", idx), observed(), e);
        end
    endtask

    initial begin
        int bad_onehot;
        // reset/idle, basic instruction, ack wait, jump, stall, halt, reset over ack
        vecs[0]  = v(0,0,0,0,4'h1,4'h0,F_IDL ,8'h00);
        vecs[1]  = v(0,1,1,0,4'h1,4'h0,F_IDL ,8'h00);
        vecs[2]  = v(0,0,1,0,4'h1,4'h0,F_HI  ,8'h00);
        vecs[3]  = v(0,0,1,0,4'h1,4'h0,F_LO  ,8'h00);
        vecs[4]  = v(0,0,1,0,4'h1,4'h0,F_DEC ,8'h01);
        vecs[5]  = v(0,0,1,0,4'h1,4'h0,F_EXA ,8'h01);
        vecs[6]  = v(0,1,0,0,4'h1,4'h0,F_WAIT,8'h01);
        vecs[7]  = v(0,1,0,0,4'h1,4'h0,F_WAIT,8'h01);
        vecs[8]  = v(0,1,0,0,4'h1,4'h0,F_WAIT,8'h01);
        vecs[9]  = v(0,0,1,0,4'h1,4'h0,F_HI  ,8'h01);
        vecs[10] = v(0,0,1,0,4'hE,4'hA,F_LO  ,8'h01);
        vecs[11] = v(0,0,1,0,4'hE,4'hA,F_DEC ,8'h02);
        vecs[12] = v(0,0,1,0,4'hE,4'hA,F_DEC ,8'h02);
        vecs[13] = v(0,0,1,0,4'h1,4'h0,F_HI  ,8'h0A);
        vecs[14] = v(0,0,1,0,4'h1,4'h0,F_LO  ,8'h0A);
        vecs[15] = v(0,1,1,1,4'h1,4'h0,F_DEC ,8'h0B);
        vecs[16] = v(0,0,1,1,4'h1,4'h0,F_DEC ,8'h0B);
        vecs[17] = v(0,0,1,1,4'h1,4'h0,F_DEC ,8'h0B);
        vecs[18] = v(0,0,1,0,4'h1,4'h0,F_EXA ,8'h0B);
        vecs[19] = v(0,0,1,0,4'hF,4'h0,F_HI  ,8'h0B);
        vecs[20] = v(0,0,1,0,4'hF,4'h0,F_LO  ,8'h0B);
        vecs[21] = v(0,0,1,0,4'hF,4'h0,F_DEC ,8'h0C);
        vecs[22] = v(0,1,1,0,4'hF,4'h0,F_HALT,8'h0C);
        vecs[23] = v(0,0,0,0,4'hF,4'h0,F_HALT,8'h0C);
        vecs[24] = v(1,1,1,0,4'hF,4'h0,F_HALT,8'h0C);
        vecs[25] = v(0,0,0,0,4'h1,4'h0,F_IDL ,8'h00);
        vecs[26] = v(0,1,0,0,4'h1,4'h0,F_IDL ,8'h00);
        vecs[27] = v(1,0,1,0,4'h1,4'h0,F_WAIT,8'h00);
        vecs[28] = v(0,0,1,0,4'h1,4'h0,F_IDL ,8'h00);

        res = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < NV; i++) apply(i);

        // PC wrap: 255 back-to-back instructions from pc=0 reach 0xFF, the next fetch wraps to 0.
        bad_onehot = 0;
        mem_ack = 1'b1; opcode = 4'h1; operand = 4'h0; stall = 1'b0; res = 1'b0;
        for (int i = 0; i < 1 + 4 * 255; i++) begin
            @(negedge clk);
            start = (i == 0);
            #2;
            if (32'(ir_hi_en) + 32'(ir_lo_en) + 32'(acc_en) > 1) bad_onehot++;
        end
        @(negedge clk); #2;
        check("pc_ff_fetch_hi", {mem_req, mem_half, pc}, {1'b1, 1'b0, 8'hFF});
        @(negedge clk); #2;
        check("fetch_lo_at_ff", {mem_req, mem_half, ir_lo_en, pc}, {1'b1, 1'b1, 1'b1, 8'hFF});
        @(negedge clk); #2;
        check("pc_wrap_zero", {busy, mem_req, pc}, {1'b1, 1'b0, 8'h00});
        check("enable_onehot", 15'(bad_onehot), 15'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
